pipelined_add_sub: RTL and testbench
====================================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per pipeline stage; WIDTH % CHUNK == 0 SHALL hold, elaboration error otherwise.
REQ-003 Parameter STEP, default 4: constant used by the inc/dec operations.
REQ-004 Ports: clk in 1, rising-edge clock; rst_n in 1, reset; one clock; reset is synchronous and active-low.
REQ-005 Ports: in_valid in 1; in_ready out 1; a in WIDTH; b in WIDTH; op in 2 (00 add, 01 sub, 10 inc, 11 dec).
REQ-006 Ports: out_valid out 1; out_ready in 1; result out WIDTH; cout out 1; ovf out 1; zero out 1.

Function
REQ-007 NSTAGES = WIDTH/CHUNK; stage k SHALL add bits [CHUNK*k+CHUNK-1 : CHUNK*k] with the carry registered out of stage k-1 (stage 0 carry-in per REQ-009).
REQ-008 Effective B: add -> b; sub -> ~b; inc -> STEP; dec -> ~STEP (STEP zero-extended to WIDTH); b ignored for inc/dec.
REQ-009 Stage-0 carry-in SHALL be 1 for sub and dec, 0 for add and inc.
REQ-010 Not-yet-added upper operand slices and the completed lower result slices SHALL travel with their transaction (skewed pipeline); no two transactions share state.
REQ-011 Latency SHALL be exactly NSTAGES cycles from an accepted input (in_valid & in_ready at edge) to out_valid with that result, absent stalls.
REQ-012 Throughput SHALL be one transaction per cycle while out_ready is held high.
REQ-013 Advance enable adv = ~out_valid | out_ready; in_ready SHALL equal adv; when adv=0 every stage register, including outputs, SHALL hold.
REQ-014 Bubbles (in_valid=0 at an advancing edge) SHALL propagate as invalid slots; out_valid SHALL be high only for real transactions.
REQ-015 cout = carry out of bit WIDTH-1 (for sub/dec, 1 means no borrow).
REQ-016 ovf = signed two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-017 zero = 1 iff result == 0.
REQ-018 result, cout, ovf, zero SHALL be registered and stable while out_valid & ~out_ready.
REQ-019 Wrap-around: results are modulo 2^WIDTH; no saturation.
REQ-020 Simultaneous accept at input and drain at output in the same cycle SHALL both occur, no loss or duplication.

Reset
REQ-021 While rst_n=0 at a clk edge, all stage valid bits SHALL clear; out_valid=0, result=0, cout=0, ovf=0, zero=0 on the following cycle.
REQ-022 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear at the output afterwards.
REQ-023 in_ready SHALL be 1 in the first cycle after reset deasserts (pipeline empty).
REQ-024 Datapath registers other than those in REQ-021 need not be reset.

Structure
REQ-025 Shared package SHALL hold op encodings (OP_ADD, OP_SUB, OP_INC, OP_DEC) and the default STEP constant.
REQ-026 One sub-module, cla_chunk (CHUNK-bit carry-lookahead adder returning sum, carry-out, carry into MSB), SHALL be instantiated once per stage.
REQ-027 Stage logic SHALL use a generate loop over NSTAGES; no behavioural "+" on the full WIDTH.

Verification (WIDTH=32, CHUNK=8, STEP=4, latency 4)
REQ-028 add a=0x0000_00FF, b=0x0000_0001 -> after 4 cycles result=0x0000_0100, cout=0, ovf=0, zero=0 (carry crosses stage boundary).
REQ-029 sub a=5, b=5 -> result=0, cout=1, zero=1; sub a=0, b=1 -> result=0xFFFF_FFFF, cout=0.
REQ-030 add a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, ovf=1; inc a=0xFFFF_FFFC -> result=0, cout=1, zero=1; dec a=2 -> result=0xFFFF_FFFE, cout=0.
REQ-031 Back-to-back 8 random ops with out_ready=1 -> 8 results on 8 consecutive cycles starting cycle 4, in order, matching model.
REQ-032 out_ready=0 for 3 cycles with full pipeline -> in_ready=0, outputs held stable, no drops; release -> remaining results in order.
REQ-033 rst_n=0 for one cycle with 3 transactions in flight -> out_valid=0 next cycle, none of the 3 ever emitted, in_ready=1 after release.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined add/sub unit: operation encodings and
// the default increment/decrement step.
package pipelined_add_sub_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_INC = 2'b10;
   localparam logic [1:0] OP_DEC = 2'b11;

   localparam int DEFAULT_STEP = 4;

   // Subtract-style ops add the inverted operand plus one.
   function automatic logic op_inverts(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_DEC);
   endfunction

endpackage

// File: rtl/pipelined_add_sub_cla_chunk.sv
// CHUNK-bit carry-lookahead adder slice; also exposes the carry into its MSB
// so the final stage can derive signed overflow.
module cla_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK-1:0] gen;
   logic [CHUNK-1:0] prop;
   logic [CHUNK:0]   carry;
   logic             acc;
   logic             pchain;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Each carry is the flat OR of generate terms gated by the propagate run above them.
   always_comb begin
      carry    = '0;
      carry[0] = cin;
      acc      = 1'b0;
      pchain   = 1'b1;
      for (int i = 0; i < CHUNK; i++) begin
         acc    = 1'b0;
         pchain = 1'b1;
         for (int j = i; j >= 0; j--) begin
            acc    = acc | (pchain & gen[j]);
            pchain = pchain & prop[j];
         end
         carry[i+1] = acc | (pchain & cin);
      end
   end

   assign sum   = prop ^ carry[CHUNK-1:0];
   assign cout  = carry[CHUNK];
   assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Skewed-pipeline add/sub/inc/dec: one CHUNK-bit slice resolved per stage,
// operands and partial sums travel with each transaction.
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int STEP  = DEFAULT_STEP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSTAGES = WIDTH / CHUNK;
   localparam logic [WIDTH-1:0] STEP_EXT = WIDTH'(STEP);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin0;

   always_comb begin
      b_eff = b;
      case (op)
         OP_SUB:  b_eff = ~b;
         OP_INC:  b_eff = STEP_EXT;
         OP_DEC:  b_eff = ~STEP_EXT;
         default: b_eff = b;
      endcase
   end

   assign cin0     = op_inverts(op);
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   logic             v_in    [NSTAGES];
   logic [WIDTH-1:0] a_in    [NSTAGES];
   logic [WIDTH-1:0] b_in    [NSTAGES];
   logic [WIDTH-1:0] sum_in  [NSTAGES];
   logic [WIDTH-1:0] sum_nxt [NSTAGES];
   logic             c_in    [NSTAGES];
   logic             c_out   [NSTAGES];
   logic             c_msb   [NSTAGES];

   logic             q_valid [NSTAGES];
   logic [WIDTH-1:0] q_a     [NSTAGES];
   logic [WIDTH-1:0] q_b     [NSTAGES];
   logic [WIDTH-1:0] q_sum   [NSTAGES];
   logic             q_c     [NSTAGES];
   logic             ovf_q;
   logic             zero_q;

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      logic [CHUNK-1:0] chunk_sum;

      if (k == 0) begin : g_head
         assign v_in[k]   = in_valid;
         assign a_in[k]   = a;
         assign b_in[k]   = b_eff;
         assign sum_in[k] = '0;
         assign c_in[k]   = cin0;
      end else begin : g_body
         assign v_in[k]   = q_valid[k-1];
         assign a_in[k]   = q_a[k-1];
         assign b_in[k]   = q_b[k-1];
         assign sum_in[k] = q_sum[k-1];
         assign c_in[k]   = q_c[k-1];
      end

      cla_chunk #(.CHUNK(CHUNK)) u_cla (
         .a     (a_in[k][CHUNK*k +: CHUNK]),
         .b     (b_in[k][CHUNK*k +: CHUNK]),
         .cin   (c_in[k]),
         .sum   (chunk_sum),
         .cout  (c_out[k]),
         .c_msb (c_msb[k])
      );

      // Unfilled upper slices of a partial sum are always zero, so OR-in is enough.
      assign sum_nxt[k] = sum_in[k] | (WIDTH'(chunk_sum) << (CHUNK*k));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGES; k++) begin
            q_valid[k] <= 1'b0;
         end
         q_sum[NSTAGES-1] <= '0;
         q_c[NSTAGES-1]   <= 1'b0;
         ovf_q            <= 1'b0;
         zero_q           <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < NSTAGES; k++) begin
            q_valid[k] <= v_in[k];
            q_a[k]     <= a_in[k];
            q_b[k]     <= b_in[k];
            q_sum[k]   <= sum_nxt[k];
            q_c[k]     <= c_out[k];
         end
         ovf_q  <= c_out[NSTAGES-1] ^ c_msb[NSTAGES-1];
         zero_q <= (sum_nxt[NSTAGES-1] == '0);
      end
   end

   assign out_valid = q_valid[NSTAGES-1];
   assign result    = q_sum[NSTAGES-1];
   assign cout      = q_c[NSTAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=32, CHUNK=8, STEP=4): directed
// vectors push expectations, a monitor pops and compares on each output handshake.
module tb_pipelined_add_sub;
   import pipelined_add_sub_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_out    = 0;

   typedef struct {
      logic [W-1:0] res;
      logic [2:0]   flags;
      int           acc_cyc;
      bit           lat;
   } exp_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } vec_t;

   exp_t sb[$];

   vec_t dir_v [6] = '{
      '{OP_ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0},
      '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0},
      '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
      '{OP_INC, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0},
      '{OP_DEC, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE, 1'b0, 1'b0}
   };

   vec_t b2b_v [8] = '{
      '{OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0},
      '{OP_SUB, 32'h1000_0000, 32'h0000_0001, 32'h0FFF_FFFF, 1'b1, 1'b0},
      '{OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0},
      '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1},
      '{OP_INC, 32'h7FFF_FFFD, 32'h0000_0000, 32'h8000_0001, 1'b0, 1'b1},
      '{OP_DEC, 32'h8000_0002, 32'h0000_0000, 32'h7FFF_FFFE, 1'b1, 1'b1},
      '{OP_ADD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0},
      '{OP_INC, 32'h0000_00FC, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 1'b0}
   };

   vec_t stall_v [6] = '{
      '{OP_ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0},
      '{OP_SUB, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0},
      '{OP_INC, 32'h0000_0010, 32'h0000_0000, 32'h0000_0014, 1'b0, 1'b0},
      '{OP_DEC, 32'h0000_0010, 32'h0000_0000, 32'h0000_000C, 1'b1, 1'b0},
      '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0},
      '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0}
   };

   pipelined_add_sub #(.WIDTH(32), .CHUNK(8), .STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance with in_valid still high.
   task automatic send(input vec_t v, input bit lat);
      exp_t e;
      bit   ok;
      in_valid = 1'b1;
      op       = v.op;
      a        = v.a;
      b        = v.b;
      ok       = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         #1;
         if (in_ready) begin
            e.res     = v.res;
            e.flags   = {v.c, v.v, (v.res == '0)};
            e.acc_cyc = cyc;
            e.lat     = lat;
            sb.push_back(e);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=in_ready_low required=accept");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: compare on each output handshake, and check outputs hold while stalled.
   logic         held = 1'b0;
   logic [W-1:0] h_res;
   logic [2:0]   h_flags;

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (out_valid && held) begin
            chk("hold_result", result, h_res);
            chk("hold_flags", {cout, ovf, zero}, h_flags);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%0h required=none", result);
            end else begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("flags_cout_ovf_zero", {cout, ovf, zero}, e.flags);
               if (e.lat) chk("latency", cyc - e.acc_cyc, 4);
            end
         end
         held    = out_valid && !out_ready;
         h_res   = result;
         h_flags = {cout, ovf, zero};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  snap;
      bit  seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = OP_ADD;
      a         = '0;
      b         = '0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {cout, ovf, zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Isolated transactions with bubbles in between.
      for (int i = 0; i < 6; i++) begin
         send(dir_v[i], 1'b1);
         idle(6);
      end

      // Back-to-back stream with out_ready held high.
      for (int i = 0; i < 8; i++) send(b2b_v[i], 1'b1);
      idle(8);

      // Stall with a full pipeline, then release.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(stall_v[i], 1'b0);
            idle(1);
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
               @(negedge clk);
               #1;
               if (out_valid) seen = 1'b1;
            end
            if (!seen) begin
               checks++;
               failures++;
               $display("FAIL stall_fill_timeout actual=no_out_valid required=out_valid");
            end
            for (int t = 0; t < 3; t++) begin
               chk("stall_in_ready", in_ready, 0);
               chk("stall_out_valid", out_valid, 1);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      idle(8);

      // Reset with three transactions in flight.
      for (int i = 0; i < 3; i++) send(b2b_v[i], 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      sb.delete();
      @(negedge clk);
      #1;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_result", result, 0);
      chk("flush_flags", {cout, ovf, zero}, 0);
      rst_n = 1'b1;
      snap  = n_out;
      chk("flush_in_ready", in_ready, 1);
      idle(10);
      chk("flush_no_emission", n_out - snap, 0);

      // One more transaction to confirm the pipeline still works after reset.
      send(dir_v[0], 1'b1);
      idle(1);
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
      chk("drain_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
